// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
// Runs one quotient bit per cycle. stall_o holds the pipeline while a divide runs.
// The result is published with a one-cycle done pulse.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               divide request (level, held by the stalled pipeline)
//   signed_op           1 = DIV (two's complement), 0 = DIVU
//   dividend, divisor   operands, sampled only when a start is accepted
//   annul               cancel the current operation (flush / exception)
//   stall_o             pipeline stall request (combinational)
//   busy                sequencer not idle
//   done                one-cycle pulse, quotient/remainder valid
//   quotient            -> LO
//   remainder           -> HI
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             stall_o,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;

    logic             accept_c;
    logic             sign_a_c, sign_b_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;
    logic [WIDTH:0]   rem_sh_c, diff_c;
    logic             last_c;

    // Operand magnitudes and signs; unsigned ops force the signs to zero
    assign sign_a_c = signed_op & dividend[WIDTH-1];
    assign sign_b_c = signed_op & divisor[WIDTH-1];
    assign abs_a_c  = sign_a_c ? (WIDTH'(0) - dividend) : dividend;
    assign abs_b_c  = sign_b_c ? (WIDTH'(0) - divisor)  : divisor;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor
    assign rem_sh_c = {rem_q, quo_q[WIDTH-1]};
    assign diff_c   = rem_sh_c - {1'b0, dvs_q};
    assign last_c   = (cnt_q == CW'(WIDTH - 1));

    assign accept_c = (state_q == S_IDLE) & start & ~annul;

    assign stall_o   = accept_c | (state_q == S_CALC);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = q_out_q;
    assign remainder = r_out_q;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        sa_d    = sa_q;
        sb_d    = sb_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    sa_d  = sign_a_c;
                    sb_d  = sign_b_c;
                    quo_d = abs_a_c;
                    dvs_d = abs_b_c;
                    rem_d = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        // Divide by zero: fixed result, raw dividend as remainder
                        state_d = S_DONE;
                        q_out_d = '1;
                        r_out_d = dividend;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // A negative trial result (borrow into the top bit) restores
                if (diff_c[WIDTH]) begin
                    rem_d = rem_sh_c[WIDTH-1:0];
                end else begin
                    rem_d = diff_c[WIDTH-1:0];
                end
                quo_d = {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
                cnt_d = CW'(cnt_q + 1'b1);
                if (last_c) begin
                    state_d = S_DONE;
                    q_out_d = (sa_q ^ sb_q) ? (WIDTH'(0) - quo_d) : quo_d;
                    r_out_d = sa_q ? (WIDTH'(0) - rem_d) : rem_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel wins over everything and leaves the published result alone
        if (annul) begin
            state_d = S_IDLE;
            q_out_d = q_out_q;
            r_out_d = r_out_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

endmodule
